// File: rtl/mux_deser_pkg.sv
// Shared types and sizing helpers for the mux bit deserializer.
package mux_deser_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bits needed to hold a count in the range 0..w inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mux2_bit.sv
// Gate-level 2:1 bit select: z = (a & ~c) | (b & c).
module mux2_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic z
);

  logic nc;
  logic ta;
  logic tb;

  not u_not (nc, c);
  and u_and_a (ta, a, nc);
  and u_and_b (tb, b, c);
  or  u_or (z, ta, tb);

endmodule

// File: rtl/mux_bit_deserializer.sv
// Shifts per-beat mux outputs into WIDTH-bit words with a ones count and valid/ready output.
// Optional out_parity port when MUX_DESER_PARITY_EN is defined.
module mux_bit_deserializer
  import mux_deser_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [CNT_W-1:0] out_ones
`ifdef MUX_DESER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  state_e           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] ones;
  logic             z;
  logic             accept_c;
  logic [WIDTH-1:0] shreg_nxt_c;
  logic [CNT_W-1:0] ones_nxt_c;

  mux2_bit u_mux (
    .a (a),
    .b (b),
    .c (c),
    .z (z)
  );

  // z is only consumed when a beat is accepted, so X on idle inputs never lands in state.
  assign accept_c    = in_valid && in_ready && (state == FILL);
  assign shreg_nxt_c = {shreg[WIDTH-2:0], z};
  assign ones_nxt_c  = ones + CNT_W'(z);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      bit_cnt   <= '0;
      shreg     <= '0;
      ones      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_word  <= '0;
      out_ones  <= '0;
`ifdef MUX_DESER_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (accept_c) begin
            shreg <= shreg_nxt_c;
            ones  <= ones_nxt_c;
            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
              // Last bit of the word: publish it and stop accepting.
              bit_cnt   <= '0;
              state     <= HOLD;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              out_word  <= shreg_nxt_c;
              out_ones  <= ones_nxt_c;
`ifdef MUX_DESER_PARITY_EN
              out_parity <= ^shreg_nxt_c;
`endif
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= FILL;
            shreg     <= '0;
            ones      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_bit_deserializer.sv
// Randomized and directed bench for mux_bit_deserializer against a queue-based word model.
module tb_mux_bit_deserializer;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          a = 1'b0;
  logic          b = 1'b0;
  logic          c = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_word;
  logic [CW-1:0] out_ones;
`ifdef MUX_DESER_PARITY_EN
  logic          out_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: accepted bits collected in order, word formed when W are present.
  bit           q_bits[$];
  bit           m_hold;
  logic [W-1:0] m_word;
  int           m_ones;

  always #5 clk = ~clk;

  mux_bit_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_ones  (out_ones)
`ifdef MUX_DESER_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  // Apply one cycle of inputs, advance the clock, and update the model.
  task automatic cycle(input bit rst, input bit v, input bit ia, input bit ib,
                       input bit ic, input bit ordy);
    reset     = rst;
    in_valid  = v;
    a         = ia;
    b         = ib;
    c         = ic;
    out_ready = ordy;
    @(posedge clk);
    if (rst) begin
      q_bits.delete();
      m_hold = 1'b0;
      m_word = '0;
      m_ones = 0;
    end else if (!m_hold && v) begin
      q_bits.push_back(ic ? ib : ia);
      if (q_bits.size() == W) begin
        m_ones = 0;
        for (int i = 0; i < W; i++) begin
          m_word[W-1-i] = q_bits[i];
          m_ones += int'(q_bits[i]);
        end
        m_hold = 1'b1;
        q_bits.delete();
      end
    end else if (m_hold && ordy) begin
      m_hold = 1'b0;
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_word !== '0 || out_ones !== '0) begin
      n_fail++;
      $display("FAIL reset: valid=%b ready=%b word=%h ones=%0d, want 0 1 00 0",
               out_valid, in_ready, out_word, out_ones);
    end
  endtask

  task automatic test_truth_table();
    logic [2:0] abc;
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      cycle(1'b0, 1'b1, abc[2], abc[1], abc[0], 1'b1);
      if (i < 7) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL truth_early_valid beat %0d: got %b want 0", i, out_valid);
        end
      end
    end
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_word !== 8'b00011011 || out_ones !== CW'(4)) begin
      n_fail++;
      $display("FAIL truth_word: valid=%b ready=%b word=%b ones=%0d, want 1 0 00011011 4",
               out_valid, in_ready, out_word, out_ones);
    end
`ifdef MUX_DESER_PARITY_EN
    n_checks++;
    if (out_parity !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_even: got %b want 0", out_parity);
    end
`endif
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL truth_release: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < W; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_word !== 8'hFF || out_ones !== CW'(8)) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d: valid=%b ready=%b word=%h ones=%0d want 1 0 ff 8",
                 i, out_valid, in_ready, out_word, out_ones);
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_transfer: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    // Beats offered during HOLD must not count toward the next word.
    for (int i = 0; i < W - 1; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_carry: valid=%b after %0d beats want 0", out_valid, W - 1);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 8'h00 || out_ones !== CW'(0)) begin
      n_fail++;
      $display("FAIL bp_next_word: valid=%b word=%h ones=%0d want 1 00 0", out_valid, out_word, out_ones);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 2 * W; i++) begin
      cycle(1'b0, 1'(i % 2 == 0), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      n_checks++;
      if (out_valid !== m_hold || (m_hold && (out_word !== m_word || out_ones !== CW'(m_ones)))) begin
        n_fail++;
        $display("FAIL gapped cyc %0d: valid=%b word=%h ones=%0d want %b %h %0d",
                 i, out_valid, out_word, out_ones, m_hold, m_word, m_ones);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_word();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < W; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 8'h00 || out_ones !== CW'(0)) begin
      n_fail++;
      $display("FAIL reset_mid_word: valid=%b word=%h ones=%0d want 1 00 0", out_valid, out_word, out_ones);
    end
    // Reset while holding discards the word.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_hold: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_parity_odd();
    for (int i = 0; i < W; i++) cycle(1'b0, 1'b1, 1'(i == W - 1), 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (out_word !== 8'b00000001 || out_ones !== CW'(1)) begin
      n_fail++;
      $display("FAIL odd_word: word=%b ones=%0d want 00000001 1", out_word, out_ones);
    end
`ifdef MUX_DESER_PARITY_EN
    n_checks++;
    if (out_parity !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_odd: got %b want 1", out_parity);
    end
`endif
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom_range(0, 2) != 0));
      n_checks++;
      if (out_valid !== m_hold || in_ready !== !m_hold ||
          (m_hold && (out_word !== m_word || out_ones !== CW'(m_ones)))) begin
        n_fail++;
        $display("FAIL random cyc %0d: valid=%b ready=%b word=%h ones=%0d want %b %b %h %0d",
                 i, out_valid, in_ready, out_word, out_ones, m_hold, !m_hold, m_word, m_ones);
      end
`ifdef MUX_DESER_PARITY_EN
      if (m_hold) begin
        n_checks++;
        if (out_parity !== ^m_word) begin
          n_fail++;
          $display("FAIL random_parity cyc %0d: got %b want %b", i, out_parity, ^m_word);
        end
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_backpressure();
    test_gapped();
    test_reset_mid_word();
    test_parity_odd();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_bit_deserializer.md
Name: mux_bit_deserializer

Overview:
- Downstream consumer of the 2:1 select function z = (a & ~c) | (b & c).
- Each accepted input beat evaluates z, and the block shifts that bit into a WIDTH-bit word.
- When the word is full, the block presents it with a population count on a valid/ready output handshake.
- Turns the combinational lab function into a clocked, flow-controlled bit stream stage.

Parameters:
- WIDTH, 8, number of z bits per output word (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), width of bit-count and ones-count fields (derived, not overridden).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a/b/c carry a valid beat this cycle.
- a  input  1  data input selected when c=0.
- b  input  1  data input selected when c=1.
- c  input  1  select.
- in_ready  output  1  block accepts a beat this cycle.
- out_valid  output  1  out_word/out_ones valid.
- out_ready  input  1  downstream accepts the word.
- out_word  output  WIDTH  assembled word; first-accepted bit ends in MSB.
- out_ones  output  CNT_W  number of 1 bits in out_word.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: state=FILL, bit_cnt=0, shift register=0, ones accumulator=0, out_valid=0, in_ready=1 after reset deasserts, out_word=0, out_ones=0.
- Beat z: z = c ? b : a, computed combinationally per beat. The value is only meaningful on accept (in_valid & in_ready).
- FILL state:
  - in_ready=1, out_valid=0.
  - On accept: shreg <= {shreg[WIDTH-2:0], z}; ones <= ones + z; bit_cnt <= bit_cnt + 1.
  - If accepting while bit_cnt==WIDTH-1: bit_cnt <= 0 and the state moves to HOLD.
  - If in_valid=0, nothing changes.
- HOLD state:
  - out_valid=1, in_ready=0. out_word=shreg and out_ones=ones, both held stable.
  - On out_valid & out_ready: state <= FILL, shreg <= 0, ones <= 0.
  - The block does not accept a new beat in the same cycle the word is consumed. Sustained throughput is WIDTH beats per WIDTH+1 cycles.
- Latency: out_valid rises on the cycle after the WIDTH-th accepted beat.
- Backpressure: while out_ready=0 in HOLD, outputs hold indefinitely and inputs are ignored. in_valid beats during HOLD are not consumed.
- Wrap-around: bit_cnt counts 0..WIDTH-1 and never exceeds WIDTH-1. ones saturates naturally at WIDTH, so CNT_W bits always suffice.
- Reset mid-word or mid-HOLD: reset wins over every other event. A partial word or a held word is discarded, and nothing is emitted.
- X handling: a/b/c are don't-care when in_valid=0. X on those inputs must not corrupt state.

Optional Feature:
- Macro: MUX_DESER_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR reduction of out_word, i.e. out_ones[0].
  - Registered alongside the word, with the same valid timing.
  - Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package mux_deser_pkg:
  - State enum FILL=1'b0, HOLD=1'b1.
  - Default WIDTH constant.
  - A function computing the CNT_W width.
- Sub-module mux2_bit (combinational z = (a&~c)|(b&c), gate-level not/and/or) is instantiated once.
- The FSM, shift register and counters stay in mux_bit_deserializer.

Test Plan:
- Reset check: assert reset 2 cycles -> out_valid=0, in_ready=1, out_word=0, out_ones=0.
- Full truth table, WIDTH=8: beats (a,b,c) = 000,001,010,011,100,101,110,111, in_valid=1 continuously, out_ready=1 -> z sequence 0,0,0,1,1,0,1,1. One cycle later out_word=8'b00011011 and out_ones=4. Next cycle in_ready=1 again.
- Backpressure: complete a word of all z=1 (a=1,c=0) with out_ready=0 for 5 cycles -> out_word=8'hFF and out_ones=8 stable, in_ready=0. Beats driven during HOLD are not counted. Raising out_ready gives one transfer.
- Gapped input: 8 beats with in_valid toggling 1/0 -> out_word depends only on accepted beats; out_valid rises 1 cycle after the 8th accept.
- Reset mid-word: accept 5 beats with z=1, then pulse reset, then 8 beats with z=0 -> out_word=8'h00, out_ones=0. No stale bits.
- With MUX_DESER_PARITY_EN: word 8'b00011011 -> out_parity=0; word 8'b00000001 -> out_parity=1.
